uart_ring_dma: RTL and testbench
================================

// Module: uart_ring_dma
// PURPOSE
//  Parametrised UART-to-RAM ring writer. Buffers received bytes in a FIFO, packs them into 32-bit
//  words and writes them into a circular RAM window [ADR_LL, ADR_UL). Sits between the servant CPU
//  Wishbone memory port and servant_ram, stealing bus cycles only when the CPU bus is idle.
//  Adds packing, partial-word flush, overflow reporting and a fixed-priority arbiter.
// PARAMETERS
//  FIFO_DEPTH  16           byte FIFO entries; power of two, >=2
//  PACK        1            1: 4 bytes per word (little-endian); 0: 1 byte per word, sel=4'b0001
//  ADR_LL      32'h00C00000 ring lower bound, inclusive, word aligned
//  ADR_UL      32'h00C10000 ring upper bound, exclusive, word aligned, > ADR_LL
//  FLUSH_CYC   1024         idle cycles before a partial word is written (PACK=1 only); 0 = never
// PORTS
//  i_wb_clk     in   1   clock
//  i_wb_rst_n   in   1   asynchronous reset, active low
//  i_rx_dat     in   8   received byte
//  i_rx_valid   in   1   one-cycle strobe; i_rx_dat is valid in that cycle
//  i_cpu_adr    in   32  CPU Wishbone address
//  i_cpu_dat    in   32  CPU write data
//  i_cpu_sel    in   4   CPU byte selects
//  i_cpu_we     in   1   CPU write enable
//  i_cpu_cyc    in   1   CPU cycle request
//  o_cpu_rdt    out  32  read data to CPU (passes i_mem_rdt)
//  o_cpu_ack    out  1   ack to CPU; only asserted while the CPU owns the bus
//  o_mem_adr    out  32  RAM address
//  o_mem_dat    out  32  RAM write data
//  o_mem_sel    out  4   RAM byte selects
//  o_mem_we     out  1   RAM write enable
//  o_mem_cyc    out  1   RAM cycle
//  i_mem_rdt    in   32  RAM read data
//  i_mem_ack    in   1   RAM ack
//  o_wr_ptr     out  32  next ring write address
//  o_level      out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
//  o_overflow   out  1   sticky: a byte was dropped
//  i_clr_ovf    in   1   clears o_overflow
// BEHAVIOUR
//  Reset (async, i_wb_rst_n=0): o_mem_cyc/we/o_cpu_ack=0, o_wr_ptr=ADR_LL, o_level=0,
//   o_overflow=0, packer empty, arbiter IDLE; an in-flight RAM cycle is abandoned immediately.
//  FIFO: push on i_rx_valid when not full; pop when packer accepts a byte. Push while full drops
//   the byte and sets o_overflow, even if a pop occurs that cycle. Set beats i_clr_ovf same cycle.
//  Packer: PACK=1 collects bytes 0..3 into lanes [7:0]..[31:24]; word ready at 4 bytes. PACK=0:
//   word ready per byte, data in [7:0], upper lanes 0. Packer stalls (no pop) while a word is pending.
//  Flush: PACK=1, FLUSH_CYC>0, 1..3 bytes held and no pop for FLUSH_CYC cycles -> word ready with
//   sel covering only held lanes (1 byte=4'b0001, 2=4'b0011, 3=4'b0111). Counter resets on any pop.
//  Arbiter states IDLE, CPU, DMA (registered grant):
//   IDLE: i_cpu_cyc=1 -> CPU (priority); else word ready -> DMA.
//   CPU: RAM signals mirror CPU; leave to IDLE on i_mem_ack while i_cpu_cyc drops after ack.
//   DMA: o_mem_cyc=we=1, adr=o_wr_ptr, dat/sel from packer; on i_mem_ack -> IDLE, packer cleared.
//   CPU request arriving in DMA is held (o_cpu_ack=0) until DMA completes; no CPU starvation:
//   after a DMA completion with i_cpu_cyc=1 the next grant is CPU.
//  Latency: word ready in IDLE with CPU idle -> o_mem_cyc next cycle; servant_ram acks 1 cycle later.
//  Pointer: on DMA ack o_wr_ptr += 4; if result >= ADR_UL it becomes ADR_LL (wrap, no overflow).
//   Partial flush words also advance the pointer by 4.
//  Outputs in IDLE: o_mem_cyc=0, o_mem_we=0, adr/dat/sel hold last value.
// STRUCTURE
//  Shared package: arbiter state encoding (IDLE/CPU/DMA), sel-mask-from-count constant table.
//  Sub-module: byte_fifo (sync FIFO, FIFO_DEPTH x 8, level/full/empty). Packer, flush timer,
//  arbiter and pointer logic stay in this module.
// TESTING
//  PACK=1: bytes 11,22,33,44 on i_rx_valid, CPU idle -> one write adr=00C00000 dat=44332211 sel=F; o_wr_ptr=00C00004.
//  PACK=0: byte A5 -> write adr=00C00000 dat=000000A5 sel=1.
//  ADR_UL=00C00010, 5 words -> addresses C00000,04,08,0C,C00000; o_wr_ptr ends 00C00004.
//  FIFO_DEPTH=4, CPU holds cyc continuously, 5 bytes -> o_level=4, o_overflow=1; i_clr_ovf -> 0.
//  FLUSH_CYC=8, bytes 01,02 then idle -> after 8 cycles write dat=00000201 sel=3.
//  CPU cyc raised during DMA cycle -> o_cpu_ack stays 0 until DMA ack, then CPU served next; reset mid-DMA -> o_mem_cyc=0 at once.

Source files
------------

// File: rtl/uart_ring_dma_pkg.sv
// Shared types for the UART ring writer: arbiter state encoding and the
// byte-count to write-select lookup used by the packer.
package uart_ring_dma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_CPU,
        ARB_DMA
    } arb_state_e;

    // Lanes covered by a word holding 'cnt' bytes (lane 0 first).
    function automatic logic [3:0] sel_mask(input logic [2:0] cnt);
        logic [3:0] m;
        case (cnt)
            3'd0:    m = 4'b0000;
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/uart_ring_dma_if.sv
// Classic Wishbone memory-port bundle (adr/dat/sel/we/cyc -> rdt/ack).
interface uart_ring_dma_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, sel, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/uart_ring_dma_byte_fifo.sv
// Synchronous byte FIFO with occupancy; pushes while full are ignored.
module byte_fifo #(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    dout_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_q];
    assign level_o = cnt_q;

    // Storage array: written on accepted pushes only.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= din_i;
    end

    // Read/write pointers and occupancy (pointers wrap naturally, DEPTH is 2^n).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
        end
    end
endmodule

// File: rtl/uart_ring_dma.sv
// UART-to-RAM ring writer: FIFO -> word packer -> bus-stealing DMA into a
// circular window [ADR_LL, ADR_UL), arbitrated against the CPU memory port.
module uart_ring_dma
    import uart_ring_dma_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned PACK       = 1,
    parameter  logic [31:0] ADR_LL     = 32'h00C00000,
    parameter  logic [31:0] ADR_UL     = 32'h00C10000,
    parameter  int unsigned FLUSH_CYC  = 1024,
    localparam int unsigned LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            i_wb_clk,
    input  logic            i_wb_rst_n,
    input  logic [7:0]      i_rx_dat,
    input  logic            i_rx_valid,
    uart_ring_dma_if.slave  cpu,
    uart_ring_dma_if.master mem,
    output logic [31:0]     o_wr_ptr,
    output logic [LW-1:0]   o_level,
    output logic            o_overflow,
    input  logic            i_clr_ovf
);
    localparam bit          FLUSH_EN   = (PACK != 0) && (FLUSH_CYC != 0);
    localparam logic [31:0] FLUSH_LAST = 32'(FLUSH_CYC - 1);

    arb_state_e  state_q;
    logic [31:0] hold_adr_q, hold_dat_q, wr_ptr_q, ptr_inc, ptr_d;
    logic [3:0]  hold_sel_q, pk_sel_q;
    logic [31:0] pk_data_q, flush_q;
    logic [2:0]  pk_cnt_q;
    logic        pk_ready_q, ovf_q;
    logic [7:0]  fifo_dout;
    logic        fifo_full, fifo_empty, fifo_pop, dma_done;

    assign fifo_pop = !pk_ready_q && !fifo_empty;
    assign dma_done = (state_q == ARB_DMA) && mem.ack;
    assign ptr_inc  = wr_ptr_q + 32'd4;
    assign ptr_d    = (ptr_inc >= ADR_UL) ? ADR_LL : ptr_inc;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (i_wb_clk),
        .rst_ni  (i_wb_rst_n),
        .push_i  (i_rx_valid),
        .din_i   (i_rx_dat),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .level_o (o_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Sticky drop flag; a drop in the same cycle wins over a clear.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n)                   ovf_q <= 1'b0;
        else if (i_rx_valid && fifo_full)  ovf_q <= 1'b1;
        else if (i_clr_ovf)                ovf_q <= 1'b0;
    end

    // Packer and flush timer: fill lanes, raise ready, clear on DMA completion.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            pk_data_q  <= '0;
            pk_cnt_q   <= '0;
            pk_ready_q <= 1'b0;
            pk_sel_q   <= '0;
            flush_q    <= '0;
        end else if (dma_done) begin
            pk_data_q  <= '0;
            pk_cnt_q   <= '0;
            pk_ready_q <= 1'b0;
            pk_sel_q   <= '0;
            flush_q    <= '0;
        end else if (fifo_pop) begin
            flush_q <= '0;
            if (PACK != 0) begin
                pk_data_q[{pk_cnt_q[1:0], 3'b000} +: 8] <= fifo_dout;
                pk_cnt_q <= pk_cnt_q + 3'd1;
                if (pk_cnt_q == 3'd3) begin
                    pk_ready_q <= 1'b1;
                    pk_sel_q   <= 4'b1111;
                end
            end else begin
                pk_data_q  <= {24'h0, fifo_dout};
                pk_sel_q   <= 4'b0001;
                pk_ready_q <= 1'b1;
            end
        end else if (FLUSH_EN && !pk_ready_q && pk_cnt_q != 3'd0) begin
            if (flush_q == FLUSH_LAST) begin
                pk_ready_q <= 1'b1;
                pk_sel_q   <= sel_mask(pk_cnt_q);
            end else begin
                flush_q <= flush_q + 32'd1;
            end
        end
    end

    // Arbiter FSM, ring pointer and last-driven bus values for the idle hold.
    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q    <= ARB_IDLE;
            wr_ptr_q   <= ADR_LL;
            hold_adr_q <= '0;
            hold_dat_q <= '0;
            hold_sel_q <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (cpu.cyc)         state_q <= ARB_CPU;
                    else if (pk_ready_q) state_q <= ARB_DMA;
                end
                ARB_CPU: begin
                    hold_adr_q <= cpu.adr;
                    hold_dat_q <= cpu.dat;
                    hold_sel_q <= cpu.sel;
                    if (mem.ack) state_q <= ARB_IDLE;
                end
                ARB_DMA: begin
                    hold_adr_q <= wr_ptr_q;
                    hold_dat_q <= pk_data_q;
                    hold_sel_q <= pk_sel_q;
                    if (mem.ack) begin
                        state_q  <= ARB_IDLE;
                        wr_ptr_q <= ptr_d;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end

    // Bus steering from the registered grant.
    always_comb begin
        mem.adr = hold_adr_q;
        mem.dat = hold_dat_q;
        mem.sel = hold_sel_q;
        mem.we  = 1'b0;
        mem.cyc = 1'b0;
        cpu.ack = 1'b0;
        cpu.rdt = mem.rdt;
        unique case (state_q)
            ARB_CPU: begin
                mem.adr = cpu.adr;
                mem.dat = cpu.dat;
                mem.sel = cpu.sel;
                mem.we  = cpu.we;
                mem.cyc = cpu.cyc;
                cpu.ack = mem.ack;
            end
            ARB_DMA: begin
                mem.adr = wr_ptr_q;
                mem.dat = pk_data_q;
                mem.sel = pk_sel_q;
                mem.we  = 1'b1;
                mem.cyc = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_wr_ptr   = wr_ptr_q;
    assign o_overflow = ovf_q;
endmodule

// File: tb/tb_uart_ring_dma.sv
// Bench for uart_ring_dma: a packed 4-deep instance with a 4-word ring and
// short flush, plus a byte-per-word instance; RAM writes checked via queues.
module tb_uart_ring_dma;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    wr_t q_a[$];
    wr_t q_b[$];

    // Instance A: PACK=1, FIFO_DEPTH=4, 4-word ring, FLUSH_CYC=8
    logic [7:0]  rx_dat_a;
    logic        rx_valid_a, clr_a, ovf_a;
    logic [31:0] wr_ptr_a;
    logic [2:0]  level_a;
    uart_ring_dma_if cpu_a ();
    uart_ring_dma_if mem_a ();

    uart_ring_dma #(
        .FIFO_DEPTH (4),
        .PACK       (1),
        .ADR_LL     (32'h00C00000),
        .ADR_UL     (32'h00C00010),
        .FLUSH_CYC  (8)
    ) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_rx_dat   (rx_dat_a),
        .i_rx_valid (rx_valid_a),
        .cpu        (cpu_a),
        .mem        (mem_a),
        .o_wr_ptr   (wr_ptr_a),
        .o_level    (level_a),
        .o_overflow (ovf_a),
        .i_clr_ovf  (clr_a)
    );

    // Instance B: PACK=0, defaults otherwise
    logic [7:0]  rx_dat_b;
    logic        rx_valid_b, clr_b, ovf_b;
    logic [31:0] wr_ptr_b;
    logic [4:0]  level_b;
    uart_ring_dma_if cpu_b ();
    uart_ring_dma_if mem_b ();

    uart_ring_dma #(
        .PACK (0)
    ) dut0 (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_rx_dat   (rx_dat_b),
        .i_rx_valid (rx_valid_b),
        .cpu        (cpu_b),
        .mem        (mem_b),
        .o_wr_ptr   (wr_ptr_b),
        .o_level    (level_b),
        .o_overflow (ovf_b),
        .i_clr_ovf  (clr_b)
    );

    // servant_ram-like responders: ack one cycle after cyc, read data tagged by address
    assign mem_a.rdt = {16'hBEEF, mem_a.adr[15:0]};
    assign mem_b.rdt = {16'hBEEF, mem_b.adr[15:0]};
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_a.ack <= 1'b0;
            mem_b.ack <= 1'b0;
        end else begin
            mem_a.ack <= mem_a.cyc & ~mem_a.ack;
            mem_b.ack <= mem_b.cyc & ~mem_b.ack;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Scoreboard monitors: every acked RAM write must match the next expected word
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && mem_a.cyc && mem_a.we && mem_a.ack) begin
            e = '{adr: '1, dat: '1, sel: 4'h0};
            if (q_a.size() > 0) e = q_a.pop_front();
            check_eq("a_wr_adr", mem_a.adr, e.adr);
            check_eq("a_wr_dat", mem_a.dat, e.dat);
            check_eq("a_wr_sel", 32'(mem_a.sel), 32'(e.sel));
        end
        if (rst_n && mem_b.cyc && mem_b.we && mem_b.ack) begin
            e = '{adr: '1, dat: '1, sel: 4'h0};
            if (q_b.size() > 0) e = q_b.pop_front();
            check_eq("b_wr_adr", mem_b.adr, e.adr);
            check_eq("b_wr_dat", mem_b.dat, e.dat);
            check_eq("b_wr_sel", 32'(mem_b.sel), 32'(e.sel));
        end
    end

    task automatic exp_a(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        q_a.push_back('{adr: adr, dat: dat, sel: sel});
    endtask

    // Called at a negedge; strobes one byte for exactly one cycle
    task automatic rx_a(input logic [7:0] b);
        rx_dat_a   = b;
        rx_valid_a = 1'b1;
        @(negedge clk);
        rx_valid_a = 1'b0;
    endtask

    task automatic drain_a(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (q_a.size() == 0) break;
            @(negedge clk);
        end
        check_eq(tag, 32'(q_a.size()), 32'd0);
    endtask

    task automatic wait_dma_a(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (mem_a.cyc && mem_a.we) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_cpu_ack_a(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cpu_a.ack) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        rx_dat_a = '0; rx_valid_a = 1'b0; clr_a = 1'b0;
        rx_dat_b = '0; rx_valid_b = 1'b0; clr_b = 1'b0;
        cpu_a.adr = '0; cpu_a.dat = '0; cpu_a.sel = 4'hF; cpu_a.we = 1'b0; cpu_a.cyc = 1'b0;
        cpu_b.adr = '0; cpu_b.dat = '0; cpu_b.sel = 4'hF; cpu_b.we = 1'b0; cpu_b.cyc = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_ptr", wr_ptr_a, 32'h00C00000);
        check_eq("rst_level", 32'(level_a), 32'd0);
        check_eq("rst_ovf", 32'(ovf_a), 32'd0);
        check_eq("rst_cyc", 32'(mem_a.cyc), 32'd0);
        check_eq("rst_we", 32'(mem_a.we), 32'd0);
        check_eq("rst_cpu_ack", 32'(cpu_a.ack), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full word, little-endian lanes
        exp_a(32'h00C00000, 32'h44332211, 4'hF);
        rx_a(8'h11); rx_a(8'h22); rx_a(8'h33); rx_a(8'h44);
        drain_a("word_drain");
        check_eq("word_ptr", wr_ptr_a, 32'h00C00004);

        // Byte-per-word instance
        q_b.push_back('{adr: 32'h00C00000, dat: 32'h000000A5, sel: 4'h1});
        rx_dat_b = 8'hA5; rx_valid_b = 1'b1;
        @(negedge clk);
        rx_valid_b = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (q_b.size() == 0) break;
            @(negedge clk);
        end
        check_eq("b_drain", 32'(q_b.size()), 32'd0);
        check_eq("b_ptr", wr_ptr_b, 32'h00C00004);

        // Partial-word flush after 8 idle cycles
        exp_a(32'h00C00004, 32'h00000201, 4'h3);
        rx_a(8'h01); rx_a(8'h02);
        repeat (5) @(negedge clk);
        check_eq("flush_not_early", 32'(q_a.size()), 32'd1);
        drain_a("flush_drain");
        check_eq("flush_ptr", wr_ptr_a, 32'h00C00008);

        // Overflow: CPU hogs the bus; packer holds one word, FIFO fills, 9th byte drops
        cpu_a.adr = 32'h00C00040; cpu_a.we = 1'b0; cpu_a.cyc = 1'b1;
        @(negedge clk);
        rx_a(8'hA0); rx_a(8'hA1); rx_a(8'hA2); rx_a(8'hA3);
        repeat (3) @(negedge clk);
        rx_a(8'hB0); rx_a(8'hB1); rx_a(8'hB2); rx_a(8'hB3); rx_a(8'hB4);
        repeat (2) @(negedge clk);
        check_eq("ovf_level", 32'(level_a), 32'd4);
        check_eq("ovf_set", 32'(ovf_a), 32'd1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        check_eq("ovf_clr", 32'(ovf_a), 32'd0);
        check_eq("ovf_ptr_held", wr_ptr_a, 32'h00C00008);
        exp_a(32'h00C00008, 32'hA3A2A1A0, 4'hF);
        exp_a(32'h00C0000C, 32'hB3B2B1B0, 4'hF);
        wait_cpu_ack_a("hog_cpu_ack");
        cpu_a.cyc = 1'b0;
        drain_a("ovf_drain");
        check_eq("wrap_ptr", wr_ptr_a, 32'h00C00000);

        // Fifth ring word lands back at the lower bound
        exp_a(32'h00C00000, 32'h88776655, 4'hF);
        rx_a(8'h55); rx_a(8'h66); rx_a(8'h77); rx_a(8'h88);
        drain_a("wrap_drain");
        check_eq("wrap_ptr2", wr_ptr_a, 32'h00C00004);

        // CPU request arriving mid-DMA waits, then is served next
        exp_a(32'h00C00004, 32'hF0DEBC9A, 4'hF);
        rx_a(8'h9A); rx_a(8'hBC); rx_a(8'hDE); rx_a(8'hF0);
        wait_dma_a("cpu_dma_start");
        cpu_a.adr = 32'h00C00020; cpu_a.we = 1'b0; cpu_a.cyc = 1'b1;
        check_eq("cpu_ack_dma0", 32'(cpu_a.ack), 32'd0);
        @(negedge clk);
        check_eq("cpu_ack_dma1", 32'(cpu_a.ack), 32'd0);
        check_eq("dma_owns_bus", 32'(mem_a.we), 32'd1);
        wait_cpu_ack_a("cpu_served");
        check_eq("cpu_adr", mem_a.adr, 32'h00C00020);
        check_eq("cpu_we", 32'(mem_a.we), 32'd0);
        check_eq("cpu_rdt", cpu_a.rdt, 32'hBEEF0020);
        check_eq("cpu_after_dma_q", 32'(q_a.size()), 32'd0);
        cpu_a.cyc = 1'b0;
        @(negedge clk);
        check_eq("cpu_dma_ptr", wr_ptr_a, 32'h00C00008);

        // Reset during a DMA cycle drops the bus at once
        rx_a(8'h01); rx_a(8'h02); rx_a(8'h03); rx_a(8'h04);
        wait_dma_a("rst_dma_start");
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cyc", 32'(mem_a.cyc), 32'd0);
        check_eq("rst_mid_we", 32'(mem_a.we), 32'd0);
        check_eq("rst_mid_ptr", wr_ptr_a, 32'h00C00000);
        check_eq("rst_mid_level", 32'(level_a), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("post_rst_idle", 32'(mem_a.cyc), 32'd0);
        check_eq("end_q_a", 32'(q_a.size()), 32'd0);
        check_eq("end_q_b", 32'(q_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
